reaction_timer: RTL

- Round controller that sits directly downstream of the start/arming state machine.
- It consumes that block's `out` level as `start` and reuses the same player button.
- Once armed, it waits a pseudo-random number of milliseconds, lights the stimulus LED, and counts milliseconds until the player presses.
- It reports a valid reaction time or a false start to the display stage that follows.

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/ms_prescaler.sv | 27 ++
 rtl/reaction_timer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time round controller.
// The LFSR step lives here so the top and any future checker agree on it.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REACT,
        DONE,
        FOUL
    } state_t;

    localparam logic [11:0] LFSR_SEED = 12'hACE;
    // Feedback taps at bit positions 12, 11, 10 and 4 (1-based).
    localparam logic [11:0] LFSR_TAPS = 12'hE08;

    function automatic logic [11:0] lfsr_next(input logic [11:0] s);
        return {s[10:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides the system clock down to a one-cycle pulse per millisecond.
// A clear restarts the count so the first tick lands a full period later.
module ms_prescaler #(
    parameter int CLK_PER_MS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == LAST);

    always_ff @(posedge clock) begin
        if (!reset || clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Round controller: random wait, stimulus lamp, then millisecond reaction count.
// Reports either a frozen reaction time (DONE) or a false start (FOUL).
module reaction_timer #(
    parameter int CLK_PER_MS      = 50000,
    parameter int DELAY_MIN_MS    = 1000,
    parameter int DELAY_RAND_BITS = 11,
    parameter int TIME_W          = 14,
    parameter int MAX_MS          = 9999
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              button,
    output logic              led,
    output logic [TIME_W-1:0] time_ms,
    output logic              done,
    output logic              false_start,
    output logic              busy
);

    import reaction_pkg::*;

    localparam int DW = $clog2(DELAY_MIN_MS + 2**DELAY_RAND_BITS);

    state_t            r_state;
    logic              r_btn_q;
    logic              r_start_q;
    logic [11:0]       r_lfsr;
    logic [DW-1:0]     r_delay;
    logic              r_led;
    logic              r_done;
    logic              r_foul;
    logic              r_busy;
    logic [TIME_W-1:0] r_time;

    logic              w_btn_rise;
    logic              w_start_rise;
    logic              w_tick;
    logic              w_abort;
    logic              w_go_wait;
    logic              w_go_react;
    logic              w_presc_clr;
    logic [DW-1:0]     w_new_delay;
    logic [TIME_W-1:0] w_time_inc;
    logic              w_timeout;

    assign w_btn_rise   = button & ~r_btn_q;
    assign w_start_rise = start & ~r_start_q;

    // Abort outranks every other event, including a simultaneous press.
    assign w_abort = (r_state != IDLE) && !start;

    assign w_go_wait = start &&
        (((r_state == IDLE) && (w_start_rise || w_btn_rise)) ||
         (((r_state == DONE) || (r_state == FOUL)) && w_btn_rise));

    assign w_go_react  = start && (r_state == WAIT) && !w_btn_rise &&
                         w_tick && (r_delay == DW'(1));
    assign w_presc_clr = w_go_wait || w_go_react;

    assign w_new_delay = DW'(DELAY_MIN_MS) + DW'(r_lfsr[DELAY_RAND_BITS-1:0]);
    assign w_time_inc  = r_time + 1'b1;
    assign w_timeout   = (w_time_inc == TIME_W'(MAX_MS));

    ms_prescaler #(
        .CLK_PER_MS(CLK_PER_MS)
    ) u_presc (
        .clock(clock),
        .reset(reset),
        .clear(w_presc_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_btn_q   <= 1'b0;
            r_start_q <= 1'b0;
            r_lfsr    <= LFSR_SEED;
            r_delay   <= '0;
            r_led     <= 1'b0;
            r_done    <= 1'b0;
            r_foul    <= 1'b0;
            r_busy    <= 1'b0;
            r_time    <= '0;
        end else begin
            r_btn_q   <= button;
            r_start_q <= start;
            r_lfsr    <= lfsr_next(r_lfsr);

            if (w_abort) begin
                r_state <= IDLE;
                r_led   <= 1'b0;
                r_done  <= 1'b0;
                r_foul  <= 1'b0;
                r_busy  <= 1'b0;
                r_time  <= '0;
            end else if (w_go_wait) begin
                r_state <= WAIT;
                r_delay <= w_new_delay;
                r_led   <= 1'b0;
                r_done  <= 1'b0;
                r_foul  <= 1'b0;
                r_busy  <= 1'b1;
                r_time  <= '0;
            end else begin
                case (r_state)
                    WAIT: begin
                        if (w_btn_rise) begin
                            r_state <= FOUL;
                            r_foul  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_go_react) begin
                            r_state <= REACT;
                            r_led   <= 1'b1;
                            r_time  <= '0;
                        end else if (w_tick) begin
                            r_delay <= r_delay - 1'b1;
                        end
                    end
                    REACT: begin
                        // A press on a tick cycle keeps the pre-increment time.
                        if (w_btn_rise) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_led   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else if (w_tick) begin
                            r_time <= w_time_inc;
                            if (w_timeout) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                                r_led   <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign led         = r_led;
    assign time_ms     = r_time;
    assign done        = r_done;
    assign false_start = r_foul;
    assign busy        = r_busy;

endmodule
